// File: rtl/interrupt_controller_pkg.sv
// Shared encodings for the interrupt controller: hazard control unit states,
// controller FSM states and default vector table layout.
package interrupt_controller_pkg;

  typedef enum logic [2:0] {
    HCU_NORMAL       = 3'h0,
    HCU_HALT         = 3'h1,
    HCU_INTERRUPT    = 3'h2,
    HCU_STALL_FETCH  = 3'h3,
    HCU_STALL_DECODE = 3'h4,
    HCU_RETURN1      = 3'h5,
    HCU_RETURN2      = 3'h6,
    HCU_RETURN3      = 3'h7
  } hcu_state_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_SERVICE = 2'd2
  } ctrl_state_e;

  localparam logic [13:0] DEFAULT_VECTOR_BASE   = 14'h0040;
  localparam int          DEFAULT_VECTOR_STRIDE = 4;

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: lowest set bit wins, valid flags any request.
module irq_priority_encoder #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    // Scan downward so the lowest index is the last (and winning) assignment.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Latches rising-edge IRQs, arbitrates enabled sources by fixed priority and
// hands one interrupt at a time to the hazard control unit.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int          NUM_IRQ       = 8,
  parameter int          ID_W          = 3,
  parameter logic [13:0] VECTOR_BASE   = DEFAULT_VECTOR_BASE,
  parameter int          VECTOR_STRIDE = DEFAULT_VECTOR_STRIDE
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_wr_en,
  input  logic [NUM_IRQ-1:0] mask_wr_data,
  input  logic               global_en_wr,
  input  logic               global_en_data,
  input  logic [2:0]         control_state,
  output logic               interrupt,
  output logic [13:0]        interrupt_vector_address,
  output logic [NUM_IRQ-1:0] pending,
  output logic               in_service,
  output logic [ID_W-1:0]    active_id
);

  ctrl_state_e        state;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] mask;
  logic               global_en;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clear_vec;
  logic               accept;
  logic               sel_valid;
  logic [ID_W-1:0]    sel_id;

  function automatic logic [13:0] vector_of(input logic [ID_W-1:0] id);
    logic [31:0] addr;
    addr = 32'(VECTOR_BASE) + 32'(id) * 32'(VECTOR_STRIDE);
    return addr[13:0];
  endfunction

  irq_priority_encoder #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prio (
    .req   (pending & mask),
    .valid (sel_valid),
    .id    (sel_id)
  );

  assign rise      = irq & ~irq_q;
  assign accept    = (state == ST_REQUEST) && (control_state == HCU_INTERRUPT);
  assign clear_vec = accept ? (NUM_IRQ'(1) << active_id) : '0;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, and every register has an async reset value.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      irq_q     <= '0;
      pending   <= '0;
      mask      <= '0;
      global_en <= 1'b0;
    end else begin
      irq_q   <= irq;
      // A new edge on the source being accepted re-arms it: set wins.
      pending <= (pending & ~clear_vec) | rise;
      if (mask_wr_en)   mask      <= mask_wr_data;
      if (global_en_wr) global_en <= global_en_data;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state                    <= ST_IDLE;
      interrupt                <= 1'b0;
      interrupt_vector_address <= '0;
      in_service               <= 1'b0;
      active_id                <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (global_en && sel_valid) begin
            state                    <= ST_REQUEST;
            interrupt                <= 1'b1;
            active_id                <= sel_id;
            interrupt_vector_address <= vector_of(sel_id);
          end
        end
        ST_REQUEST: begin
          // Once raised, the request stands regardless of mask/global writes.
          if (accept) begin
            state      <= ST_SERVICE;
            interrupt  <= 1'b0;
            in_service <= 1'b1;
          end
        end
        ST_SERVICE: begin
          if (control_state == HCU_RETURN3) begin
            state      <= ST_IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          interrupt  <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: inputs change and outputs are
// sampled on the falling edge, half a cycle from the active rising edge.
module tb_interrupt_controller;

  logic        clock = 1'b0;
  logic        nreset;
  logic [7:0]  irq;
  logic        mask_wr_en;
  logic [7:0]  mask_wr_data;
  logic        global_en_wr;
  logic        global_en_data;
  logic [2:0]  control_state;
  logic        interrupt;
  logic [13:0] interrupt_vector_address;
  logic [7:0]  pending;
  logic        in_service;
  logic [2:0]  active_id;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  interrupt_controller dut (
    .clock                    (clock),
    .nreset                   (nreset),
    .irq                      (irq),
    .mask_wr_en               (mask_wr_en),
    .mask_wr_data             (mask_wr_data),
    .global_en_wr             (global_en_wr),
    .global_en_data           (global_en_data),
    .control_state            (control_state),
    .interrupt                (interrupt),
    .interrupt_vector_address (interrupt_vector_address),
    .pending                  (pending),
    .in_service               (in_service),
    .active_id                (active_id)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_irq(input logic [7:0] lines);
    irq = lines;
    step(1);
    irq = '0;
  endtask

  task automatic do_accept();
    control_state = 3'h2;
    step(1);
    control_state = 3'h0;
  endtask

  task automatic do_return();
    control_state = 3'h7;
    step(1);
    control_state = 3'h0;
  endtask

  task automatic check_request(input string tag, input logic [2:0] id, input logic [13:0] vec);
    check({tag, "_int"}, 32'(interrupt), 32'd1);
    check({tag, "_id"},  32'(active_id), 32'(id));
    check({tag, "_vec"}, 32'(interrupt_vector_address), 32'(vec));
  endtask

  initial begin
    nreset         = 1'b0;
    irq            = '0;
    mask_wr_en     = 1'b0;
    mask_wr_data   = '0;
    global_en_wr   = 1'b0;
    global_en_data = 1'b0;
    control_state  = 3'h0;
    step(2);
    check("rst_int",     32'(interrupt), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_insvc",   32'(in_service), 32'd0);
    check("rst_vec",     32'(interrupt_vector_address), 32'd0);
    check("rst_id",      32'(active_id), 32'd0);
    nreset = 1'b1;

    // Enable everything.
    mask_wr_en = 1'b1; mask_wr_data = 8'hFF;
    global_en_wr = 1'b1; global_en_data = 1'b1;
    step(1);
    mask_wr_en = 1'b0; global_en_wr = 1'b0;

    // Single source: capture, then request two clocks after the edge.
    pulse_irq(8'h08);
    check("t1_pending", 32'(pending), 32'h08);
    check("t1_int_early", 32'(interrupt), 32'd0);
    step(1);
    check_request("t1", 3'd3, 14'h004C);
    do_accept();
    check("t1_insvc", 32'(in_service), 32'd1);
    check("t1_int_off", 32'(interrupt), 32'd0);
    check("t1_pend_clr", 32'(pending), 32'h00);
    do_return();
    check("t1_insvc_done", 32'(in_service), 32'd0);

    // Simultaneous sources: lowest index wins, the other waits.
    pulse_irq(8'h22);
    check("t2_pending", 32'(pending), 32'h22);
    step(1);
    check_request("t2a", 3'd1, 14'h0044);
    do_accept();
    check("t2_pending_after", 32'(pending), 32'h20);
    do_return();
    step(1);
    check_request("t2b", 3'd5, 14'h0054);
    do_accept();
    do_return();

    // Masked source stays pending until unmasked.
    mask_wr_en = 1'b1; mask_wr_data = 8'hFE;
    step(1);
    mask_wr_en = 1'b0;
    pulse_irq(8'h01);
    check("t3_pending", 32'(pending), 32'h01);
    step(2);
    check("t3_masked_int", 32'(interrupt), 32'd0);
    mask_wr_en = 1'b1; mask_wr_data = 8'hFF;
    step(1);
    mask_wr_en = 1'b0;
    check("t3_int_next", 32'(interrupt), 32'd0);
    step(1);
    check_request("t3", 3'd0, 14'h0040);
    do_accept();
    do_return();

    // Acceptance and a new edge of the same source in one cycle: set wins.
    pulse_irq(8'h04);
    step(1);
    check_request("t4a", 3'd2, 14'h0048);
    control_state = 3'h2;
    irq = 8'h04;
    step(1);
    control_state = 3'h0;
    irq = '0;
    check("t4_insvc", 32'(in_service), 32'd1);
    check("t4_pending", 32'(pending), 32'h04);
    do_return();
    step(1);
    check_request("t4b", 3'd2, 14'h0048);
    do_accept();
    do_return();

    // Edge during service waits for the return.
    pulse_irq(8'h40);
    step(1);
    check_request("t5a", 3'd6, 14'h0058);
    do_accept();
    pulse_irq(8'h10);
    check("t5_pending", 32'(pending), 32'h10);
    step(3);
    check("t5_int_held", 32'(interrupt), 32'd0);
    do_return();
    step(1);
    check_request("t5b", 3'd4, 14'h0050);

    // Asynchronous reset mid-request clears state without a clock edge.
    pulse_irq(8'h80);
    #2;
    nreset = 1'b0;
    #1;
    check("t6_int",     32'(interrupt), 32'd0);
    check("t6_pending", 32'(pending), 32'd0);
    check("t6_insvc",   32'(in_service), 32'd0);
    check("t6_vec",     32'(interrupt_vector_address), 32'd0);
    check("t6_id",      32'(active_id), 32'd0);
    step(1);
    nreset = 1'b1;

    // After reset global enable and mask are off: capture without request.
    pulse_irq(8'h02);
    check("t7_pending", 32'(pending), 32'h02);
    step(2);
    check("t7_int_gated", 32'(interrupt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Source side of the pipeline interrupt interface: latches external interrupt requests and arbitrates among enabled sources by fixed priority.
- Presents a single `interrupt` request plus a 14-bit `interrupt_vector_address` to the hazard control unit.
- Tracks that unit's `control_state` to detect acceptance (INTERRUPT state) and service completion (RETURN3 state).
- Sits between peripheral IRQ lines and the hazard control unit; one interrupt in service at a time, no nesting.

Parameters:
- NUM_IRQ, 8: number of request sources.
- ID_W, 3: width of source index, clog2(NUM_IRQ).
- VECTOR_BASE, 14'h0040: vector address of source 0.
- VECTOR_STRIDE, 4: word spacing between consecutive vectors.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- nreset  in  1  asynchronous, active-low reset.
- irq  in  NUM_IRQ  request lines, synchronous to clock, rising-edge sensitive.
- mask_wr_en  in  1  load enable mask this cycle.
- mask_wr_data  in  NUM_IRQ  new per-source enable mask; 1 = enabled.
- global_en_wr  in  1  load global enable this cycle.
- global_en_data  in  1  new global enable value.
- control_state  in  3  hazard control unit state; 3'h2 = INTERRUPT, 3'h7 = RETURN3.
- interrupt  out  1  request to hazard control unit.
- interrupt_vector_address  out  14  vector of the selected source.
- pending  out  NUM_IRQ  latched pending bits, for readback.
- in_service  out  1  an accepted interrupt awaits return.
- active_id  out  ID_W  index of the requested or in-service source.

Behaviour:
- Reset (async, nreset=0): state=IDLE, pending=0, mask=0, global_en=0, irq_q=0, interrupt=0, vector=0, in_service=0, active_id=0.
- Edge detect: rise[i] = irq[i] & ~irq_q[i]; irq_q <= irq each cycle. A line held high across reset release is captured once, in the first cycle.
- Pending: pending[i] sets on rise[i], regardless of mask. It clears only on acceptance of source i. If set and clear occur in the same cycle, set wins.
- Mask and global enable gate arbitration only, never pending capture. Writes take effect the next cycle.
- Arbitration: eligible = pending & mask. Lowest index has highest priority. Computed combinationally; used only in IDLE.
- Vector: VECTOR_BASE + id*VECTOR_STRIDE, truncated to 14 bits. Registered when entering REQUEST. Held constant through REQUEST and SERVICE.
- FSM:
  - IDLE: interrupt=0. If global_en and eligible!=0, latch id and vector, then go to REQUEST next cycle.
  - REQUEST: interrupt=1. On posedge with control_state==3'h2, clear pending[id], set in_service=1, go to SERVICE. Mask or global changes do not withdraw a committed request.
  - SERVICE: interrupt=0, in_service=1, vector held. On control_state==3'h7, clear in_service and go to IDLE. New edges still accumulate in pending.
- Latency:
  - Edge to interrupt=1 is 2 clocks minimum: capture, then IDLE->REQUEST.
  - Re-arbitration starts the cycle after returning to IDLE.
- The hazard control unit updates on negedge. control_state is stable at each posedge, so no synchronization is required.
- Reset mid-request or mid-service aborts immediately to reset values. The hazard control unit is reset by the same nreset.

Decomposition:
- Shared package holds:
  - hazard control unit state encodings: NORMAL 3'h0, HALT 3'h1, INTERRUPT 3'h2, STALL_FETCH 3'h3, STALL_DECODE 3'h4, RETURN1 3'h5, RETURN2 3'h6, RETURN3 3'h7.
  - controller state encodings: IDLE, REQUEST, SERVICE.
  - vector base and stride constants.
- One sub-module, irq_priority_encoder: combinational, NUM_IRQ-bit vector in, valid plus ID_W index out.

Test Plan:
- Reset, then mask=8'hFF, global_en=1. Pulse irq[3] for 1 cycle -> pending=8'h08. Two clocks later interrupt=1, active_id=3, vector=14'h004C.
- Raise irq[5] and irq[1] in the same cycle -> active_id=1, vector=14'h0044. After control_state=2 then 7, pending=8'h20. Next request: id 5, vector 14'h0054.
- mask=8'hFE, pulse irq[0] -> pending=8'h01, interrupt stays 0. Write mask=8'hFF -> interrupt=1 with id 0, vector 14'h0040.
- In REQUEST for id 2, drive control_state=2 and pulse irq[2] in the same cycle -> in_service=1 and pending[2] stays 1. After control_state=7, id 2 is re-requested.
- During SERVICE, pulse irq[4] -> interrupt stays 0 until control_state=7. Then interrupt=1 with vector 14'h0050.
- Assert nreset=0 asynchronously mid-REQUEST -> interrupt, pending, in_service and vector go to 0 immediately, without waiting for a clock edge.
